serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Sequences a single mux-based full-adder cell (8:1 mux truth-table sum/carry) as a bit-serial
//   WIDTH-bit adder. Captures operands on start, feeds one bit pair per clock LSB-first through the
//   cell with a registered carry, and assembles the result. Sits between a host/test FSM and the
//   shared 1-bit FA datapath; start/busy/done handshake.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=2); also number of RUN cycles
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous reset, active-high
//   start  in   1      request; sampled only in IDLE or DONE
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   cin    in   1      carry-in, captured on accepted start
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse; sum/cout valid
//   sum    out  WIDTH  result; holds until next accepted start
//   cout   out  1      final carry; holds until next accepted start
// BEHAVIOUR
//   - Reset (async, any state, mid-operation included): state=IDLE, busy=0, done=0, sum=0, cout=0,
//     bit counter=0, carry reg=0, operand shift regs=0. Partial result discarded.
//   - FSM: IDLE -start-> RUN; RUN -(cnt==WIDTH-1)-> DONE; DONE -start-> RUN, else -> IDLE.
//   - Accept (IDLE/DONE & start): a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum<=0.
//   - RUN, each edge: {s,c} = FA(a_sh[0], b_sh[0], carry); sum<={s,sum[WIDTH-1:1]};
//     a_sh,b_sh>>1; carry<=c; cnt<=cnt+1. On last bit also cout<=c.
//   - FA evaluated as 8:1 mux: index {a,b,c}; sum=SUM_TT[idx], carry=CARRY_TT[idx].
//   - Latency: start sampled at edge k -> bits at edges k+1..k+WIDTH -> done high for the cycle
//     after edge k+WIDTH (WIDTH+1 cycles after accept). busy high exactly WIDTH cycles.
//   - start while busy: ignored, no effect on operands or progress.
//   - start coincident with done: accepted (back-to-back); done still pulses one cycle.
//   - Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
//   - cnt width = $clog2(WIDTH); wraps are unreachable (reset to 0 on accept).
// CONFIGURATION
//   SERIAL_ADDER_SUB_EN defined: extra input port sub (1 bit), captured on accept. sub=1 ->
//     b_sh<=~b, carry<=1 (cin ignored); result = a - b, cout=1 means no borrow. sub=0 as add.
//   Not defined: no sub port; add only, cin used as given.
// STRUCTURE
//   serial_adder_pkg: state enum {IDLE, RUN, DONE}; SUM_TT=8'b1001_0110; CARRY_TT=8'b1110_1000.
//   Sub-module mux8_full_adder: combinational 1-bit FA, inputs a,b,c, outputs s,co, built as
//     two 8:1 truth-table muxes from the package constants. Controller holds all state.
// TESTING
//   1. WIDTH=8, a=0x5A b=0x3C cin=0, start 1 cycle -> busy 8 cycles, done at +9, sum=0x96 cout=0.
//   2. a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1; a=0x00 b=0x00 cin=1 -> sum=0x01 cout=0.
//   3. start pulsed at RUN cycle 3 with a=0x11 b=0x22 -> ignored; result of first op unchanged.
//   4. rst asserted at RUN cycle 4 -> same-cycle busy=0 done=0 sum=0 cout=0; IDLE after release.
//   5. start held high through done -> second op accepted on done cycle, no idle gap, both correct.
//   6. SERIAL_ADDER_SUB_EN: sub=1 a=0x10 b=0x01 -> sum=0x0F cout=1; a=0x01 b=0x02 -> 0xFF cout=0.
//   Scoreboard all: compare {cout,sum} to a+b+cin (or a-b) over 1000 random ops, random start gaps.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// The full-adder truth tables are indexed by {a, b, carry_in}.
package serial_adder_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Sum output of a full adder for index {a,b,c}: odd parity of the inputs.
    localparam logic [7:0] SUM_TT   = 8'b1001_0110;

    // Carry output of a full adder for index {a,b,c}: majority of the inputs.
    localparam logic [7:0] CARRY_TT = 8'b1110_1000;

    // Builds the 3-bit mux select from the three adder inputs.
    function automatic logic [2:0] fa_idx(input logic a, input logic b, input logic c);
        return {a, b, c};
    endfunction

endpackage

// File: rtl/mux8_full_adder.sv
// Combinational 1-bit full adder built as two 8:1 truth-table muxes.
// The select is {a, b, c}; the data inputs are the package truth tables.
module mux8_full_adder
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    logic [2:0] idx;

    assign idx = fa_idx(a, b, c);

    // Two independent 8:1 muxes sharing one select.
    always_comb begin
        s  = SUM_TT[idx];
        co = CARRY_TT[idx];
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller around a single mux-based full adder.
// Operands are captured on an accepted start and fed LSB-first, one bit pair
// per clock, through the cell with a registered carry.
//
// Handshake: start is sampled only in IDLE or DONE; when sampled high the
// operands are captured on that edge. busy is high for exactly WIDTH cycles
// while bits are processed. done is a one-cycle pulse in the cycle after the
// last bit; sum/cout are valid from then until the next accepted start.
// start while busy is ignored. start coincident with done is accepted.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input that
// turns the operation into a - b (b inverted, carry-in forced to 1; cout=1
// means no borrow).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_t           dbg_state
);

    // Counter width is clog2(WIDTH); it is reloaded on every accept, so it
    // never needs to wrap.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_co;

    // Operand B and carry-in as they are loaded on accept.
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // The shared 1-bit datapath always sees the current LSBs and carry.
    mux8_full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Select what gets loaded on accept: plain add, or two's-complement subtract.
`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load     = b;
        carry_load = cin;
        if (sub) begin
            b_load     = ~b;
            carry_load = 1'b1;
        end
    end
`else
    always_comb begin
        b_load     = b;
        carry_load = cin;
    end
`endif

    // Controller FSM: accept, shift WIDTH bits through the cell, then pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // done is only ever high for the single DONE cycle.
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // New sum bit enters at the MSB; after WIDTH shifts bit 0
                    // of the operands has landed at sum[0].
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        cout  <= fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Directed vectors with hand-computed results, then a randomized scoreboard run.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_i;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    state_t       dbg_state;

    int n_checks;
    int n_fail;

    logic [W:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub_i),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: launches one op at the current falling edge and waits for done.
    // hold keeps start high afterwards; inject_at pulses a stray start with
    // different operands at that RUN cycle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv, input logic hold,
                          input int inject_at,
                          output logic [W-1:0] r_sum, output logic r_cout,
                          output int cycles, output int busy_cnt, output logic ok);
        a = av; b = bv; cin = cv; sub_i = sv; start = 1'b1;
        cycles = 0; busy_cnt = 0; ok = 1'b0; r_sum = '0; r_cout = 1'b0;
        while (cycles < 40 && !ok) begin
            @(negedge clk);
            cycles++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                ok = 1'b1;
                r_sum = sum;
                r_cout = cout;
            end
            if (!hold) start = 1'b0;
            if (inject_at != 0 && cycles == inject_at) begin
                a = 8'h11; b = 8'h22; start = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, cout, sum} !== {3'b000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, expected all 0", busy, done, cout, sum);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] rs; logic rc; int cyc; int bc; logic ok;
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 0, rs, rc, cyc, bc, ok);
        n_checks++;
        if (!ok || {rc, rs} !== 9'h096) begin
            n_fail++;
            $display("FAIL basic_result: got ok=%b %b_%h expected 0_96", ok, rc, rs);
        end
        n_checks++;
        if (cyc !== W + 1) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected %0d", cyc, W + 1);
        end
        n_checks++;
        if (bc !== W) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, W);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || dbg_state !== IDLE || sum !== 8'h96) begin
            n_fail++;
            $display("FAIL basic_after_done: got done=%b state=%0d sum=%h expected 0 0 96", done, dbg_state, sum);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0] rs; logic rc; int cyc; int bc; logic ok;
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 0, rs, rc, cyc, bc, ok);
        n_checks++;
        if (!ok || {rc, rs} !== 9'h100) begin
            n_fail++;
            $display("FAIL corner_ff_plus_1: got %b_%h expected 1_00", rc, rs);
        end
        @(negedge clk);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, rs, rc, cyc, bc, ok);
        n_checks++;
        if (!ok || {rc, rs} !== 9'h001) begin
            n_fail++;
            $display("FAIL corner_cin_only: got %b_%h expected 0_01", rc, rs);
        end
        @(negedge clk);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 0, rs, rc, cyc, bc, ok);
        n_checks++;
        if (!ok || {rc, rs} !== 9'h1FF) begin
            n_fail++;
            $display("FAIL corner_all_ones: got %b_%h expected 1_ff", rc, rs);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] rs; logic rc; int cyc; int bc; logic ok;
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 3, rs, rc, cyc, bc, ok);
        n_checks++;
        if (!ok || {rc, rs} !== 9'h096 || cyc !== W + 1) begin
            n_fail++;
            $display("FAIL start_while_busy: got %b_%h in %0d cycles expected 0_96 in %0d", rc, rs, cyc, W + 1);
        end
        @(negedge clk);
        n_checks++;
        if (dbg_state !== IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_while_busy_idle: got state=%0d busy=%b expected 0 0", dbg_state, busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        a = 8'hA5; b = 8'h5A; cin = 1'b1; sub_i = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, cout, sum} !== {3'b000, 8'h00} || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b done=%b cout=%b sum=%h state=%0d expected zeros/IDLE", busy, done, cout, sum, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got activity=%0d state=%0d expected 0 IDLE", seen_done, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] rs; logic rc; int cyc; int bc; logic ok;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 0, rs, rc, cyc, bc, ok);
        n_checks++;
        if (!ok || {rc, rs} !== 9'h046) begin
            n_fail++;
            $display("FAIL b2b_first: got %b_%h expected 0_46", rc, rs);
        end
        run_op(8'hF0, 8'h20, 1'b1, 1'b0, 1'b0, 0, rs, rc, cyc, bc, ok);
        n_checks++;
        if (!ok || {rc, rs} !== 9'h111 || cyc !== W + 1 || bc !== W) begin
            n_fail++;
            $display("FAIL b2b_second: got %b_%h cycles=%0d busy=%0d expected 1_11 %0d %0d", rc, rs, cyc, bc, W + 1, W);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_pulse: got done=%b expected 0", done);
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [W-1:0] rs; logic rc; int cyc; int bc; logic ok;
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 0, rs, rc, cyc, bc, ok);
        n_checks++;
        if (!ok || {rc, rs} !== 9'h10F) begin
            n_fail++;
            $display("FAIL sub_no_borrow: got %b_%h expected 1_0f", rc, rs);
        end
        @(negedge clk);
        run_op(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 0, rs, rc, cyc, bc, ok);
        n_checks++;
        if (!ok || {rc, rs} !== 9'h0FF) begin
            n_fail++;
            $display("FAIL sub_borrow: got %b_%h expected 0_ff", rc, rs);
        end
        @(negedge clk);
    endtask
`endif

    // Scoreboard run: random operands, random idle gaps (0 gives back-to-back).
    task automatic test_random();
        logic [W-1:0] rs; logic rc; int cyc; int bc; logic ok;
        logic [W-1:0] av; logic [W-1:0] bv; logic cv; logic sv;
        logic [W:0] e;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            av = W'($urandom_range(0, 255));
            bv = W'($urandom_range(0, 255));
            cv = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
            sv = 1'($urandom_range(0, 1));
`else
            sv = 1'b0;
`endif
            if (sv) e = {1'b0, av} + {1'b0, ~bv} + 9'd1;
            else    e = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
            exp_q.push_back(e);
            run_op(av, bv, cv, sv, 1'b0, 0, rs, rc, cyc, bc, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || {rc, rs} !== e) begin
                n_fail++;
                $display("FAIL random_op %0d: a=%h b=%h cin=%b sub=%b got ok=%b %b_%h expected %b_%h",
                         i, av, bv, cv, sv, ok, rc, rs, e[W], e[W-1:0]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_corners();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
